// File: rtl/uart_hex_loader.sv
// ASCII-hex image loader: packs hex characters received from a UART into 32-bit words,
// writes them to instruction memory and reports status on TX. Build macro HEXLD_ECHO_EN
// echoes every received byte before its status byte.
module uart_hex_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ack,
  input  logic              tx_busy,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              err
);
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      CH_PLUS   = 8'h2B;
  localparam logic [7:0]      CH_BANG   = 8'h21;
  localparam logic [7:0]      CH_HASH   = 8'h23;
  localparam logic [7:0]      CH_PROMPT = 8'h3E;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WRITE, S_RESP, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [7:0]          rx_byte_q, rx_byte_d;
  logic [31:0]         shreg_q, shreg_d;
  logic [3:0]          nib_cnt_q, nib_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                load_done_q, load_done_d;
  logic                err_q, err_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                echo_q, echo_d;
  logic                stat_q, stat_d;
  logic [7:0]          stat_byte_q, stat_byte_d;
  logic                hash_q, hash_d;

  logic                is_hex, is_ws, is_dot, is_reload, bad;
  logic [3:0]          nib;
  logic [7:0]          head;
  logic                tx_fire;
  logic [ADDR_W:0]     wc_inc;

  // 'A'..'F' and 'a'..'f' both have low nibble 1..6, so adding 9 yields 10..15.
  always_comb begin
    is_hex    = 1'b0;
    nib       = 4'h0;
    if (rx_byte_q >= 8'h30 && rx_byte_q <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_byte_q[3:0];
    end else if ((rx_byte_q >= 8'h41 && rx_byte_q <= 8'h46) ||
                 (rx_byte_q >= 8'h61 && rx_byte_q <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_byte_q[3:0] + 4'd9;
    end
    is_ws     = (rx_byte_q == 8'h20) || (rx_byte_q == 8'h0D) || (rx_byte_q == 8'h0A);
    is_dot    = (rx_byte_q == 8'h2E);
    is_reload = (rx_byte_q == 8'h52) || (rx_byte_q == 8'h72);
  end

  // Pending TX bytes go out in order: echo, status, trailing '#'.
  always_comb begin
    if (echo_q)      head = rx_byte_q;
    else if (stat_q) head = stat_byte_q;
    else             head = CH_HASH;
  end

  assign wc_inc = word_count_q + 1'b1;

  // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    rx_byte_d    = rx_byte_q;
    shreg_d      = shreg_q;
    nib_cnt_d    = nib_cnt_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    load_done_d  = load_done_q;
    err_d        = err_q;
    tx_data_d    = tx_data_q;
    echo_d       = echo_q;
    stat_d       = stat_q;
    stat_byte_d  = stat_byte_q;
    hash_d       = hash_q;
    tx_fire      = 1'b0;
    bad          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          rx_byte_d = rx_data;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
`ifdef HEXLD_ECHO_EN
        echo_d = 1'b1;
`else
        echo_d = 1'b0;
`endif
        if (is_hex) begin
          if (!load_done_q) begin
            shreg_d   = {shreg_q[27:0], nib};
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end else if (is_ws) begin
          bad = (nib_cnt_q != 4'd0);
        end else if (is_dot) begin
          if (nib_cnt_q == 4'd0) begin
            load_done_d = 1'b1;
            stat_d      = 1'b1;
            stat_byte_d = CH_HASH;
          end else begin
            bad = 1'b1;
          end
        end else if (is_reload) begin
          addr_d       = '0;
          word_count_d = '0;
          nib_cnt_d    = 4'd0;
          shreg_d      = 32'h0;
          load_done_d  = 1'b0;
          err_d        = 1'b0;
          stat_d       = 1'b1;
          stat_byte_d  = CH_PROMPT;
        end else begin
          bad = 1'b1;
        end

        if (bad) begin
          err_d       = 1'b1;
          nib_cnt_d   = 4'd0;
          shreg_d     = 32'h0;
          stat_d      = 1'b1;
          stat_byte_d = CH_BANG;
        end

        // With nothing to send, GAP still delays the return to IDLE so the
        // just-acknowledged rx_valid has dropped before it is sampled again.
        if (is_hex && !load_done_q && nib_cnt_q == 4'd7) state_d = S_WRITE;
        else if (echo_d || stat_d)                       state_d = S_RESP;
        else                                             state_d = S_GAP;
      end

      S_WRITE: begin
        word_count_d = wc_inc;
        if (wc_inc < DEPTH_C) addr_d = addr_q + 1'b1;
        if (wc_inc == DEPTH_C) begin
          load_done_d = 1'b1;
          hash_d      = 1'b1;
        end
        nib_cnt_d   = 4'd0;
        shreg_d     = 32'h0;
        stat_d      = 1'b1;
        stat_byte_d = CH_PLUS;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (!tx_busy) begin
          tx_fire   = 1'b1;
          tx_data_d = head;
          if (echo_q)      echo_d = 1'b0;
          else if (stat_q) stat_d = 1'b0;
          else             hash_d = 1'b0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        state_d = (echo_q || stat_q || hash_q) ? S_RESP : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only, and state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_byte_q    <= 8'h0;
      shreg_q      <= 32'h0;
      nib_cnt_q    <= 4'd0;
      addr_q       <= '0;
      word_count_q <= '0;
      load_done_q  <= 1'b0;
      err_q        <= 1'b0;
      tx_data_q    <= 8'h0;
      echo_q       <= 1'b0;
      stat_q       <= 1'b0;
      stat_byte_q  <= 8'h0;
      hash_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_byte_q    <= rx_byte_d;
      shreg_q      <= shreg_d;
      nib_cnt_q    <= nib_cnt_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      load_done_q  <= load_done_d;
      err_q        <= err_d;
      tx_data_q    <= tx_data_d;
      echo_q       <= echo_d;
      stat_q       <= stat_d;
      stat_byte_q  <= stat_byte_d;
      hash_q       <= hash_d;
    end
  end

  assign rx_ack     = (state_q == S_DECODE);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = shreg_q;
  assign word_count = word_count_q;
  assign load_done  = load_done_q;
  assign err        = err_q;
  assign tx_wr      = tx_fire;
  assign tx_data    = tx_fire ? head : tx_data_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader: a character-level reference model queues expected
// memory writes and TX bytes; a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_hex_loader;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h0;
  logic              rx_ack;
  logic              tx_busy = 1'b0;
  logic              tx_wr;
  logic [7:0]        tx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              load_done;
  logic              err;

  uart_hex_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ack     (rx_ack),
    .tx_busy    (tx_busy),
    .tx_wr      (tx_wr),
    .tx_data    (tx_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .load_done  (load_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int         checks = 0;
  int         errors = 0;
  int         tx_pulses = 0;
  int         tx_pushed = 0;
  bit         busy_force = 1'b0;
  bit         busy_rand = 1'b0;

  // Reference model state: words loaded, flags, and the pending partial word as a digit list.
  int         m_count = 0;
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;
  logic [3:0] m_nibs[$];
  logic [7:0] m_last_tx = 8'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    string      digits = "0123456789abcdef";
    logic [7:0] lc;
    lc = (c >= 8'h41 && c <= 8'h5A) ? c + 8'd32 : c;
    for (int i = 0; i < 16; i++)
      if (digits[i] == lc) return i;
    return -1;
  endfunction

  function automatic void push_tx(input logic [7:0] b);
    exp_tx.push_back(b);
    m_last_tx = b;
    tx_pushed++;
  endfunction

  function automatic void model_error();
    m_err = 1'b1;
    m_nibs.delete();
    push_tx("!");
  endfunction

  function automatic void model_char(input logic [7:0] c);
    int          v;
    logic [31:0] w;
    v = hex_val(c);
`ifdef HEXLD_ECHO_EN
    push_tx(c);
`endif
    if (v >= 0) begin
      if (!m_done) begin
        m_nibs.push_back(v[3:0]);
        if (m_nibs.size() == 8) begin
          w = 32'h0;
          foreach (m_nibs[i]) w = w * 16 + 32'(m_nibs[i]);
          exp_wr.push_back('{addr: m_count[ADDR_W-1:0], data: w});
          m_nibs.delete();
          m_count++;
          push_tx("+");
          if (m_count == DEPTH) begin
            m_done = 1'b1;
            push_tx("#");
          end
        end
      end
    end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
      if (m_nibs.size() != 0) model_error();
    end else if (c == ".") begin
      if (m_nibs.size() == 0) begin
        m_done = 1'b1;
        push_tx("#");
      end else begin
        model_error();
      end
    end else if (c == "R" || c == "r") begin
      m_nibs.delete();
      m_count = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      push_tx(">");
    end else begin
      model_error();
    end
  endfunction

  // UART-side behaviour: hold rx_valid until rx_ack, clear it on the acknowledging edge.
  task automatic send_char(input logic [7:0] c);
    int n;
    model_char(c);
    @(posedge clk); #1;
    rx_data  = c;
    rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ack && n < 500);
    check("rx_ack_seen", rx_ack, 1'b1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    string up = "0123456789ABCDEF";
    string lo = "0123456789abcdef";
    for (int i = 7; i >= 0; i--) begin
      logic [3:0] d;
      d = w[i*4 +: 4];
      send_char($urandom_range(0, 1) ? up[d] : lo[d]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_tx.size() + exp_wr.size()), 64'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    int exp_addr;
    exp_addr = (m_count < DEPTH) ? m_count : DEPTH - 1;
    check({tag, "_word_count"}, word_count, m_count);
    check({tag, "_mem_addr"},   mem_addr,   exp_addr);
    check({tag, "_load_done"},  load_done,  m_done);
    check({tag, "_err"},        err,        m_err);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_count   = 0;
    m_done    = 1'b0;
    m_err     = 1'b0;
    m_last_tx = 8'h0;
    m_nibs.delete();
    @(negedge clk);
    check("reset_outputs",
          64'({rx_ack, tx_wr, tx_data, mem_we, mem_addr, mem_wdata, word_count, load_done, err}),
          64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_busy = busy_force | (busy_rand & ($urandom_range(0, 3) == 0));
    end
  end

  logic ack_prev = 1'b0;
  wr_t  mon_wr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_ack) check("rx_ack_single_cycle", ack_prev, 1'b0);
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected no write", mem_addr, mem_wdata);
        end else begin
          mon_wr = exp_wr.pop_front();
          check("write_addr", mem_addr, mon_wr.addr);
          check("write_data", mem_wdata, mon_wr.data);
        end
      end
      if (tx_wr) begin
        tx_pulses++;
        check("tx_wr_while_busy", tx_busy, 1'b0);
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got 0x%02h expected no byte", tx_data);
        end else begin
          check("tx_byte", tx_data, exp_tx.pop_front());
        end
      end
    end
    ack_prev = rx_ack;
  end

  initial begin
    int base_p;
    int base_e;
    int n_pend;
    logic [31:0] w;
    logic [7:0]  c;
    int          r;

    do_reset();

    send_str("DEADBEEF");
    drain();
    check_status("deadbeef");

    do_reset();
    send_str("00000013 00a00093");
    send_char(8'h0D);
    send_char(8'h0A);
    send_char(".");
    drain();
    check_status("two_words");

    send_char("R");
    send_str("12G");
    drain();
    check_status("bad_char");
    send_str("ABCDEF01");
    drain();
    check_status("after_bad");

    send_str("1234");
    send_char("R");
    drain();
    check_status("reload");
    send_str("CAFEF00D");
    drain();
    check_status("cafef00d");

    busy_rand = 1'b1;
    send_char("r");
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      send_word(w);
      if ($urandom_range(0, 1)) send_char(8'h20);
      else begin send_char(8'h0D); send_char(8'h0A); end
    end
    send_str("11111111");
    drain();
    check_status("full");
    busy_rand = 1'b0;

    send_str("12");
    drain();
    do_reset();
    w = $urandom;
    send_word(w);
    drain();
    check_status("reset_mid_word");

    busy_force = 1'b1;
    repeat (2) @(posedge clk);
    base_p = tx_pulses;
    base_e = tx_pushed;
    send_char("R");
    repeat (50) @(negedge clk);
    check("tx_held_while_busy", tx_pulses - base_p, 0);
    n_pend = tx_pushed - base_e;
    busy_force = 1'b0;
    drain();
    check("tx_pulses_after_busy", tx_pulses - base_p, n_pend);
    check("tx_data_holds", tx_data, m_last_tx);

    base_p = tx_pulses;
    base_e = tx_pushed;
    send_char("A");
    drain();
    check("tx_pulses_single_A", tx_pulses - base_p, tx_pushed - base_e);

    busy_rand = 1'b1;
    send_char("R");
    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      c = (hex_val(8'($urandom_range(48, 57))) >= 0 && $urandom_range(0, 1)) ?
                           8'($urandom_range(48, 57)) : 8'($urandom_range(97, 102));
      else if (r < 80) c = ($urandom_range(0, 2) == 0) ? 8'h20 : (($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      else if (r < 84) c = ".";
      else if (r < 86) c = "r";
      else             c = 8'($urandom_range(0, 255));
      send_char(c);
    end
    drain();
    check_status("random_stream");
    busy_rand = 1'b0;

    check("scoreboard_wr_empty", 64'(exp_wr.size()), 64'd0);
    check("scoreboard_tx_empty", 64'(exp_tx.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_hex_loader.md
Name: uart_hex_loader

Overview:
- Sits between the UART byte receiver/transmitter and the CPU instruction memory write port.
- Consumes ASCII hex characters from the RX byte handshake and assembles them MSB-nibble-first into 32-bit words.
- Writes each completed word to sequential instruction-memory addresses.
- Reports progress and errors back over the TX byte interface, and flags load completion so the CPU can be started.

Parameters:
- ADDR_W, 4, instruction memory address width (word addressed).
- DEPTH, 16, number of words that can be loaded; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- rx_valid  in  1  UART byte available (level, held until acknowledged).
- rx_data  in  8  received byte.
- rx_ack  out  1  one-cycle pulse; clears rx_valid in the UART.
- tx_busy  in  1  UART transmitter busy.
- tx_wr  out  1  one-cycle pulse; loads tx_data into the UART.
- tx_data  out  8  byte to transmit.
- mem_we  out  1  one-cycle instruction memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  write data.
- word_count  out  ADDR_W+1  words written since the last clear.
- load_done  out  1  sticky; image complete.
- err  out  1  sticky; protocol error seen.

Behaviour:
- Reset (rst_n=0 at posedge): FSM enters IDLE. All outputs read 0: rx_ack, tx_wr, tx_data, mem_we, mem_addr, mem_wdata, word_count, load_done, err. Nibble counter and shift register are also 0.
- Reset mid-operation discards any partial word and any pending response byte.
- FSM states:
  - IDLE: wait for a byte.
  - DECODE: classify the captured byte.
  - WRITE: perform the memory write.
  - RESP: send a response byte.
  - GAP: one mandatory spacing cycle after each tx_wr.
- IDLE → DECODE when rx_valid=1 at a posedge. The byte is captured and rx_ack=1 for exactly the following cycle.
- The FSM never returns to IDLE sooner than 2 cycles after capture, so a stale rx_valid is never re-sampled.
- Character classes in DECODE:
  - '0'-'9', 'A'-'F', 'a'-'f': shift the nibble in as shreg = {shreg[27:0], nib} and increment the nibble count.
    - On the 8th nibble → WRITE.
    - If load_done=1, the nibble is discarded silently and the counts are unchanged.
  - Space (0x20), CR (0x0D), LF (0x0A):
    - Ignored if nibble count = 0.
    - Otherwise it is an error: set err, clear the partial word, send '!'.
  - '.' with nibble count = 0: set load_done and send '#'.
  - '.' with nibble count ≠ 0: error as above.
  - 'R' or 'r': clear mem_addr, word_count, nibble count, load_done and err, then send '>'.
  - Any other byte: set err, clear the partial word, send '!'.
- WRITE (exactly one cycle):
  - mem_we=1, mem_wdata=shreg, mem_addr=current address.
  - Next cycle: address increments, word_count increments, nibble count returns to 0, then send '+'.
  - If word_count reaches DEPTH, also set load_done. The '+' is followed by '#' in the same RESP sequence.
- Address never wraps. Once DEPTH words are written, no further writes occur until 'R' or reset.
- TX handshake:
  - RESP waits while tx_busy=1.
  - When tx_busy=0, drive tx_wr=1 for one cycle with tx_data valid in that cycle, then go to GAP.
  - After GAP, either the next queued byte is sent or the FSM returns to IDLE.
- tx_data holds its last value between pulses.
- An rx byte arriving while in RESP or GAP stays pending on rx_valid and is taken at the next IDLE.
- Minimum latency, 8th hex char: rx_valid sampled at edge N → rx_ack and DECODE in cycle N+1 → mem_we in cycle N+2 → tx_wr ('+') no earlier than cycle N+3.

Optional Feature:
- Macro: HEXLD_ECHO_EN.
- Defined: every captured byte, including ignored whitespace and invalid characters, is echoed on TX first, through the same RESP/GAP handshake. The status byte ('+', '!', '#', '>') follows, if one applies.
- Not defined: only status bytes are transmitted. Whitespace and silently discarded nibbles produce no TX traffic.

Test Plan:
- Reset then "DEADBEEF": one mem_we with addr=0 and wdata=0xDEADBEEF. word_count=1, one tx_wr with tx_data=0x2B ('+'), err=0.
- "00000013 00a00093\r\n.": writes 0x00000013 @0 and 0x00A00093 @1. TX stream "++#", load_done=1, word_count=2.
- "12G4": err=1 after 'G', no mem_we, tx_data=0x21 ('!'). A following "ABCDEF01" writes 0xABCDEF01 @0 (partial word discarded).
- 16 words (DEPTH=16) then "11111111": 16 writes at addr 0-15, then load_done=1. The 17th word produces no mem_we, and addr and word_count stay at 15 and 16.
- "1234" then 'R' then "CAFEF00D": err=0 and load_done=0 after 'R', '>' sent, write 0xCAFEF00D @0. Also covers rst_n pulsed after "12": next 8 hex chars write @0 with no leftover nibbles.
- tx_busy held high 50 cycles during a response: tx_wr stays 0, then exactly one pulse after tx_busy falls. With HEXLD_ECHO_EN, input "A" yields a single tx_wr with tx_data=0x41.
